// File: rtl/pln_mc_core_if.sv
// Memory-side bundle of the PLN core: instruction fetch port and data access port,
// both using a req/ack handshake where ack is only meaningful while req is high.
interface pln_mc_core_if #(
   parameter int XLEN = 16,
   parameter int AW   = 16
);
   logic            imem_req;
   logic [AW-1:0]   imem_addr;
   logic [15:0]     imem_rdata;
   logic            imem_ack;
   logic            dmem_req;
   logic            dmem_we;
   logic [AW-1:0]   dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_rdata, imem_ack, dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/pln_mc_core.sv
// Multi-cycle PLN core: fetch/decode/execute/mem/writeback sequencer with its own
// register file, ALU and PC-relative branch logic behind req/ack memory ports.
//
//   state    | meaning
//   S_FETCH  | imem_req high until imem_ack, instruction latched on ack
//   S_DECODE | register file read
//   S_EXEC   | ALU result, data address, branch/jump target
//   S_MEM    | dmem_req high until dmem_ack (LD/ST only)
//   S_WB     | register write, pc update, retire pulse
//   S_HALT   | terminal until reset, no requests
module pln_mc_core #(
   parameter int XLEN  = 16,
   parameter int NREGS = 8,
   parameter int AW    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   pln_mc_core_if.master       bus,
   output logic [AW-1:0]       o_pc,
   output logic                o_retired,
   output logic [31:0]         o_retire_count,
   output logic                o_illegal,
   output logic                o_halted
);
   localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_started;
   logic [15:0]     r_ir;
   logic [AW-1:0]   r_pc;
   logic [AW-1:0]   r_next_pc;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_d;
   logic [XLEN-1:0] r_res;
   logic [AW-1:0]   r_dmem_addr;
   logic [XLEN-1:0] r_dmem_wdata;
   logic            r_illegal;
   logic [31:0]     r_retire_count;
   logic [XLEN-1:0] r_regs [NREGS];

   logic [3:0]      w_op;
   logic [RW-1:0]   w_rd;
   logic [RW-1:0]   w_rs1;
   logic [RW-1:0]   w_rs2;
   logic [XLEN-1:0] w_imm6;
   logic [AW-1:0]   w_pc_imm6;
   logic [AW-1:0]   w_pc_imm9;
   logic [XLEN-1:0] w_sum;
   logic [AW-1:0]   w_pc_inc;
   logic            w_is_mem;
   logic            w_writes;
   logic            w_slt;

   assign w_op      = r_ir[15:12];
   assign w_rd      = r_ir[9 +: RW];
   assign w_rs1     = r_ir[6 +: RW];
   assign w_rs2     = r_ir[3 +: RW];
   assign w_imm6    = XLEN'($signed(r_ir[5:0]));
   assign w_pc_imm6 = AW'($signed(r_ir[5:0]));
   assign w_pc_imm9 = AW'($signed(r_ir[8:0]));
   assign w_sum     = r_a + w_imm6;
   assign w_pc_inc  = r_pc + AW'(1);
   assign w_is_mem  = (w_op == 4'h7) || (w_op == 4'h8);
   assign w_writes  = (w_op <= 4'h7) || (w_op == 4'hB);
   assign w_slt     = $signed(r_a) < $signed(r_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (r_started && bus.imem_ack) w_next = S_DECODE;
         S_DECODE: w_next = S_EXEC;
         S_EXEC:   w_next = w_is_mem ? S_MEM : S_WB;
         S_MEM:    if (bus.dmem_ack) w_next = S_WB;
         S_WB:     w_next = (w_op == 4'hF) ? S_HALT : S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   // r_started keeps imem_req low while the core is still held in reset.
   always_comb begin
      bus.imem_req = (r_state == S_FETCH) && r_started;
      bus.dmem_req = (r_state == S_MEM);
      bus.dmem_we  = (r_state == S_MEM) && (w_op == 4'h8);
      o_retired    = (r_state == S_WB);
      o_halted     = (r_state == S_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_started      <= 1'b0;
         r_ir           <= '0;
         r_pc           <= '0;
         r_next_pc      <= '0;
         r_a            <= '0;
         r_b            <= '0;
         r_d            <= '0;
         r_res          <= '0;
         r_dmem_addr    <= '0;
         r_dmem_wdata   <= '0;
         r_illegal      <= 1'b0;
         r_retire_count <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         r_started <= 1'b1;
         case (r_state)
            S_FETCH: if (r_started && bus.imem_ack) r_ir <= bus.imem_rdata;
            S_DECODE: begin
               r_a <= r_regs[w_rs1];
               r_b <= r_regs[w_rs2];
               r_d <= r_regs[w_rd];
            end
            S_EXEC: begin
               r_next_pc <= w_pc_inc;
               case (w_op)
                  4'h0: r_res <= r_a + r_b;
                  4'h1: r_res <= r_a - r_b;
                  4'h2: r_res <= r_a & r_b;
                  4'h3: r_res <= r_a | r_b;
                  4'h4: r_res <= r_a ^ r_b;
                  4'h5: r_res <= {{(XLEN-1){1'b0}}, w_slt};
                  4'h6: r_res <= w_sum;
                  4'h7, 4'h8: begin
                     r_dmem_addr  <= w_sum[AW-1:0];
                     r_dmem_wdata <= r_d;
                  end
                  4'h9: if (r_d == r_a) r_next_pc <= r_pc + w_pc_imm6;
                  4'hA: if (r_d != r_a) r_next_pc <= r_pc + w_pc_imm6;
                  4'hB: begin
                     r_res     <= XLEN'(w_pc_inc);
                     r_next_pc <= r_pc + w_pc_imm9;
                  end
                  4'hC, 4'hD, 4'hE: r_illegal <= 1'b1;
                  4'hF: r_next_pc <= r_pc;
               endcase
            end
            S_MEM: if (bus.dmem_ack && (w_op == 4'h7)) r_res <= bus.dmem_rdata;
            S_WB: begin
               r_pc           <= r_next_pc;
               r_retire_count <= r_retire_count + 32'd1;
               if (w_writes && (w_rd != '0)) r_regs[w_rd] <= r_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_addr   = r_pc;
   assign bus.dmem_addr   = r_dmem_addr;
   assign bus.dmem_wdata  = r_dmem_wdata;
   assign o_pc            = r_pc;
   assign o_illegal       = r_illegal;
   assign o_retire_count  = r_retire_count;
endmodule
